divisor_secuencial: RTL and testbench

//  Sequential unsigned restoring divider. Inverse operation of the ALU's combinational
//  4-bit array multiplier. Takes a WIDTH-bit dividend and divisor and returns the

---
 rtl/alu_pkg.sv | 12 +
 rtl/restador_n.sv | 23 ++
 rtl/divisor_secuencial.sv | 139 +++++++++++++
 tb/tb_divisor_secuencial.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: divider state encoding and default operand width.
package alu_pkg;

   localparam int unsigned DIV_WIDTH_DEF = 4;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } div_state_t;

endpackage : alu_pkg

// File: rtl/restador_n.sv
// Ripple-borrow subtractor: diff = a - b, borrow set when a < b.
module restador_n #(
   parameter int unsigned WIDTH = 5
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
);

   logic [WIDTH:0] bw;

   assign bw[0] = 1'b0;

   // One full-subtractor cell per bit, borrow rippling LSB to MSB.
   for (genvar i = 0; i < int'(WIDTH); i++) begin : g_fs
      assign diff[i]  = a[i] ^ b[i] ^ bw[i];
      assign bw[i+1]  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bw[i]);
   end

   assign borrow = bw[WIDTH];

endmodule : restador_n

// File: rtl/divisor_secuencial.sv
// Sequential unsigned restoring divider with start/busy/done handshake.
module divisor_secuencial
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividendo,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] cociente,
   output logic [WIDTH-1:0] residuo,
   output logic             busy,
   output logic             done,
   output logic             div_zero
);

   localparam int unsigned W  = WIDTH;
   localparam int unsigned RW = WIDTH + 1;
   localparam int unsigned CW = $clog2(WIDTH) + 1;

   div_state_t      state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [RW-1:0]   r_q, r_d;
   logic [W-1:0]    q_q, q_d;
   logic [W-1:0]    d_q, d_d;
   logic            dz_q, dz_d;
   logic [W-1:0]    cociente_q, cociente_d;
   logic [W-1:0]    residuo_q, residuo_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            div_zero_q, div_zero_d;

   logic [RW-1:0]   r_sh;
   logic [RW-1:0]   t_diff;
   logic            t_borrow;

   // Partial remainder shifted left, pulling in the next dividend bit.
   assign r_sh = RW'({r_q, q_q[W-1]});

   restador_n #(.WIDTH(RW)) u_restador (
      .a      (r_sh),
      .b      ({1'b0, d_q}),
      .diff   (t_diff),
      .borrow (t_borrow)
   );

   // Next-state and datapath update.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      r_d        = r_q;
      q_d        = q_q;
      d_d        = d_q;
      dz_d       = dz_q;
      cociente_d = cociente_q;
      residuo_d  = residuo_q;
      div_zero_d = div_zero_q;
      done_d     = 1'b0;

      case (state_q)
         IDLE: begin
            // A start coinciding with the done pulse is dropped.
            if (start && !done_q) begin
               if (divisor != '0) begin
                  d_d     = divisor;
                  r_d     = '0;
                  q_d     = dividendo;
                  cnt_d   = CW'(W);
                  dz_d    = 1'b0;
                  state_d = CALC;
               end else begin
                  q_d     = '1;
                  r_d     = RW'(dividendo);
                  dz_d    = 1'b1;
                  state_d = DONE;
               end
            end
         end
         CALC: begin
            r_d   = t_borrow ? r_sh : t_diff;
            q_d   = W'({q_q, ~t_borrow});
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            cociente_d = q_q;
            residuo_d  = r_q[W-1:0];
            div_zero_d = dz_q;
            done_d     = 1'b1;
            state_d    = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d == CALC);
   end

   // State, datapath and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         r_q        <= '0;
         q_q        <= '0;
         d_q        <= '0;
         dz_q       <= 1'b0;
         cociente_q <= '0;
         residuo_q  <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         div_zero_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         r_q        <= r_d;
         q_q        <= q_d;
         d_q        <= d_d;
         dz_q       <= dz_d;
         cociente_q <= cociente_d;
         residuo_q  <= residuo_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         div_zero_q <= div_zero_d;
      end
   end

   assign cociente = cociente_q;
   assign residuo  = residuo_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign div_zero = div_zero_q;

endmodule : divisor_secuencial

// File: tb/tb_divisor_secuencial.sv
// Directed bench for the sequential divider.
module tb_divisor_secuencial;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [3:0] dividendo;
   logic [3:0] divisor;
   logic [3:0] cociente;
   logic [3:0] residuo;
   logic       busy;
   logic       done;
   logic       div_zero;

   int checks   = 0;
   int failures = 0;

   divisor_secuencial #(.WIDTH(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .dividendo (dividendo),
      .divisor   (divisor),
      .cociente  (cociente),
      .residuo   (residuo),
      .busy      (busy),
      .done      (done),
      .div_zero  (div_zero)
   );

   always #5 clk = ~clk;

   // Launch one operation and collect latency, busy cycles and done pulses.
   task automatic run_op(input logic [3:0] dd, input logic [3:0] dv,
                         output int lat, output int bcnt, output int npulse,
                         output logic [3:0] q, output logic [3:0] r, output logic dz);
      dividendo = dd;
      divisor   = dv;
      start     = 1'b1;
      @(posedge clk); #1;
      start  = 1'b0;
      bcnt   = busy ? 1 : 0;
      lat    = -1;
      npulse = 0;
      q      = 4'hx;
      r      = 4'hx;
      dz     = 1'bx;
      for (int n = 1; n <= 20; n++) begin
         @(posedge clk); #1;
         if (busy) bcnt++;
         if (done) begin
            npulse++;
            if (lat < 0) begin
               lat = n;
               q   = cociente;
               r   = residuo;
               dz  = div_zero;
            end
         end else if (lat >= 0) begin
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; dividendo = '0; divisor = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({cociente, residuo, busy, done, div_zero} !== 11'b0) begin
         failures++;
         $display("FAIL reset_outputs got q=%h r=%h busy=%b done=%b dz=%b want all 0",
                  cociente, residuo, busy, done, div_zero);
      end
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_basic();
      int lat, bcnt, np; logic [3:0] q, r; logic dz;
      run_op(4'd13, 4'd4, lat, bcnt, np, q, r, dz);
      checks++;
      if (lat !== 5 || bcnt !== 4 || np !== 1) begin
         failures++;
         $display("FAIL basic_timing got lat=%0d busy=%0d pulses=%0d want 5 4 1", lat, bcnt, np);
      end
      checks++;
      if (q !== 4'd3 || r !== 4'd1 || dz !== 1'b0) begin
         failures++;
         $display("FAIL basic_13_4 got q=%0d r=%0d dz=%b want 3 1 0", q, r, dz);
      end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (cociente !== 4'd3 || residuo !== 4'd1) begin
         failures++;
         $display("FAIL basic_hold got q=%0d r=%0d want 3 1", cociente, residuo);
      end
   endtask

   task automatic test_vectors();
      int dd_t[4] = '{15, 15, 0, 3};
      int dv_t[4] = '{1, 15, 5, 7};
      int eq_t[4] = '{15, 1, 0, 0};
      int er_t[4] = '{0, 0, 0, 3};
      int lat, bcnt, np; logic [3:0] q, r; logic dz;
      for (int i = 0; i < 4; i++) begin
         run_op(4'(dd_t[i]), 4'(dv_t[i]), lat, bcnt, np, q, r, dz);
         checks++;
         if (q !== 4'(eq_t[i]) || r !== 4'(er_t[i]) || dz !== 1'b0 || lat !== 5 || np !== 1) begin
            failures++;
            $display("FAIL vec_%0d_%0d got q=%0d r=%0d dz=%b lat=%0d pulses=%0d want %0d %0d 0 5 1",
                     dd_t[i], dv_t[i], q, r, dz, lat, np, eq_t[i], er_t[i]);
         end
      end
   endtask

   task automatic test_div_zero();
      int lat, bcnt, np; logic [3:0] q, r; logic dz;
      run_op(4'd7, 4'd0, lat, bcnt, np, q, r, dz);
      checks++;
      if (lat !== 1 || bcnt !== 0 || np !== 1) begin
         failures++;
         $display("FAIL dz_timing got lat=%0d busy=%0d pulses=%0d want 1 0 1", lat, bcnt, np);
      end
      checks++;
      if (q !== 4'hF || r !== 4'd7 || dz !== 1'b1) begin
         failures++;
         $display("FAIL dz_result got q=%h r=%0d dz=%b want F 7 1", q, r, dz);
      end
      run_op(4'd6, 4'd3, lat, bcnt, np, q, r, dz);
      checks++;
      if (q !== 4'd2 || r !== 4'd0 || dz !== 1'b0 || lat !== 5) begin
         failures++;
         $display("FAIL dz_clear got q=%0d r=%0d dz=%b lat=%0d want 2 0 0 5", q, r, dz, lat);
      end
   endtask

   task automatic test_ignore_start();
      int np = 0; int lat = -1; int extra_busy = 0;
      logic [3:0] q = 4'hx, r = 4'hx;
      dividendo = 4'd9; divisor = 4'd2; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      dividendo = 4'd1; divisor = 4'd1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; dividendo = 4'd15; divisor = 4'd3;
      for (int n = 3; n <= 16; n++) begin
         @(posedge clk); #1;
         if (done) begin
            np++;
            if (lat < 0) begin
               lat = n; q = cociente; r = residuo;
               // Start during the done cycle must not launch a new op.
               dividendo = 4'd5; divisor = 4'd1; start = 1'b1;
               @(posedge clk); #1;
               start = 1'b0;
               if (busy) extra_busy++;
               if (done) np++;
            end
         end else if (lat >= 0 && busy) begin
            extra_busy++;
         end
      end
      checks++;
      if (q !== 4'd4 || r !== 4'd1 || np !== 1 || lat !== 5) begin
         failures++;
         $display("FAIL ignore_calc got q=%0d r=%0d pulses=%0d lat=%0d want 4 1 1 5", q, r, np, lat);
      end
      checks++;
      if (extra_busy !== 0 || cociente !== 4'd4) begin
         failures++;
         $display("FAIL ignore_done got busy_cycles=%0d q=%0d want 0 4", extra_busy, cociente);
      end
   endtask

   task automatic test_reset_mid();
      int lat, bcnt, np; int stray = 0; logic [3:0] q, r; logic dz;
      run_op(4'd13, 4'd4, lat, bcnt, np, q, r, dz);
      dividendo = 4'd14; divisor = 4'd3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      checks++;
      if ({cociente, residuo, busy, done, div_zero} !== 11'b0) begin
         failures++;
         $display("FAIL rst_mid got q=%h r=%h busy=%b done=%b dz=%b want all 0",
                  cociente, residuo, busy, done, div_zero);
      end
      @(negedge clk); rst = 1'b0;
      for (int n = 0; n < 8; n++) begin
         @(posedge clk); #1;
         if (done || busy) stray++;
      end
      checks++;
      if (stray !== 0) begin
         failures++;
         $display("FAIL rst_no_done got active_cycles=%0d want 0", stray);
      end
      run_op(4'd14, 4'd3, lat, bcnt, np, q, r, dz);
      checks++;
      if (q !== 4'd4 || r !== 4'd2 || lat !== 5) begin
         failures++;
         $display("FAIL rst_recover got q=%0d r=%0d lat=%0d want 4 2 5", q, r, lat);
      end
   endtask

   task automatic test_back_to_back();
      int lat, bcnt, np; logic [3:0] q, r; logic dz;
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            run_op(4'(a), 4'(b), lat, bcnt, np, q, r, dz);
            checks++;
            if (b == 0) begin
               if (q !== 4'hF || r !== 4'(a) || dz !== 1'b1 || lat !== 1 || np !== 1) begin
                  failures++;
                  $display("FAIL exh_%0d_0 got q=%h r=%0d dz=%b lat=%0d want F %0d 1 1", a, q, r, dz, lat, a);
               end
            end else begin
               if (q !== 4'(a / b) || r !== 4'(a % b) || dz !== 1'b0 || lat !== 5 || np !== 1) begin
                  failures++;
                  $display("FAIL exh_%0d_%0d got q=%0d r=%0d dz=%b lat=%0d want %0d %0d 0 5",
                           a, b, q, r, dz, lat, a / b, a % b);
               end
               checks++;
               if (int'(q) * b + int'(r) != a || int'(r) >= b) begin
                  failures++;
                  $display("FAIL exh_invariant_%0d_%0d got q=%0d r=%0d", a, b, q, r);
               end
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_vectors();
      test_div_zero();
      test_ignore_start();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule : tb_divisor_secuencial
